rv32_core: RTL and testbench

Single-cycle RV32I processor core with an optional M extension. It fetches one 32-bit instruction per clock from an instruction ROM addressed by `pc_curr`, executes it, and retires it in the same cycle. Loads and stores go to a byte-maskable data RAM. It sits between the instruction ROM and the data RAM at the top of the SoC.

---
 rtl/rv32_core.sv | 214 +++++++++++++++++++++
 tb/tb_rv32_core.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/rv32_core.sv
// Single-cycle RV32I core; M extension (MUL/DIV/REM) compiled in when RV32M_EN is defined.
// CPI = 1, fetch/execute/retire in one cycle; no stalls, ROM and RAM are combinational reads.
module rv32_core #(
    parameter int PC_WIDTH   = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] data_ROM,
    output logic [PC_WIDTH-1:0]   pc_curr,
    input  logic [DATA_WIDTH-1:0] data_RAM_i,
    output logic [DATA_WIDTH-1:0] data_RAM_o,
    output logic [ADDR_WIDTH-1:0] addr_RAM_o,
    output logic [3:0]            mem_wr_mask_o,
    output logic                  mem_RAM_enable
);
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_JAL    = 7'h6f;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_OPIMM  = 7'h13;
    localparam logic [6:0] OPC_OP     = 7'h33;

    logic [PC_WIDTH-1:0] r_pc;
    logic [31:0]         r_regs [32];

    logic [31:0] w_inst, w_pc, w_pc_next, w_pc_plus4;
    logic [6:0]  w_opcode, w_funct7;
    logic [4:0]  w_rd, w_rs1, w_rs2;
    logic [2:0]  w_funct3;
    logic [31:0] w_rs1_val, w_rs2_val;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    logic        w_is_load, w_is_store, w_is_mext;

    assign w_inst     = 32'(data_ROM);
    assign w_pc       = 32'(r_pc);
    assign w_pc_plus4 = w_pc + 32'd4;
    assign w_opcode   = w_inst[6:0];
    assign w_rd       = w_inst[11:7];
    assign w_funct3   = w_inst[14:12];
    assign w_rs1      = w_inst[19:15];
    assign w_rs2      = w_inst[24:20];
    assign w_funct7   = w_inst[31:25];
    assign w_rs1_val  = r_regs[w_rs1];
    assign w_rs2_val  = r_regs[w_rs2];

    assign w_imm_i = {{20{w_inst[31]}}, w_inst[31:20]};
    assign w_imm_s = {{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
    assign w_imm_b = {{19{w_inst[31]}}, w_inst[31], w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0};
    assign w_imm_u = {w_inst[31:12], 12'd0};
    assign w_imm_j = {{11{w_inst[31]}}, w_inst[31], w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0};

    assign w_is_load  = (w_opcode == OPC_LOAD);
    assign w_is_store = (w_opcode == OPC_STORE);
    assign w_is_mext  = (w_opcode == OPC_OP) && (w_funct7 == 7'b0000001);

    // Shared integer ALU for OP and OP-IMM; SUB only exists in the register form.
    logic [31:0] w_alu_b, w_alu;
    assign w_alu_b = (w_opcode == OPC_OP) ? w_rs2_val : w_imm_i;

    always_comb begin
        w_alu = '0;
        case (w_funct3)
            3'd0: w_alu = ((w_opcode == OPC_OP) && w_funct7[5]) ? w_rs1_val - w_alu_b
                                                                : w_rs1_val + w_alu_b;
            3'd1: w_alu = w_rs1_val << w_alu_b[4:0];
            3'd2: w_alu = {31'd0, $signed(w_rs1_val) < $signed(w_alu_b)};
            3'd3: w_alu = {31'd0, w_rs1_val < w_alu_b};
            3'd4: w_alu = w_rs1_val ^ w_alu_b;
            3'd5: w_alu = w_funct7[5] ? 32'($signed(w_rs1_val) >>> w_alu_b[4:0])
                                      : w_rs1_val >> w_alu_b[4:0];
            3'd6: w_alu = w_rs1_val | w_alu_b;
            default: w_alu = w_rs1_val & w_alu_b;
        endcase
    end

`ifdef RV32M_EN
    logic signed [32:0] w_mul_a, w_mul_b;
    logic signed [63:0] w_prod;
    logic               w_div_zero, w_div_ovf;
    logic [31:0]        w_quot_s, w_rem_s, w_mext;

    // One 33x33 signed multiplier; the extra bit selects signed/unsigned per variant.
    assign w_mul_a = {(w_funct3 != 3'd3) && w_rs1_val[31], w_rs1_val};
    assign w_mul_b = {(w_funct3 == 3'd1) && w_rs2_val[31], w_rs2_val};
    assign w_prod  = w_mul_a * w_mul_b;

    assign w_div_zero = (w_rs2_val == 32'd0);
    assign w_div_ovf  = (w_rs1_val == 32'h8000_0000) && (w_rs2_val == 32'hFFFF_FFFF);
    assign w_quot_s   = 32'($signed(w_rs1_val) / $signed(w_rs2_val));
    assign w_rem_s    = 32'($signed(w_rs1_val) % $signed(w_rs2_val));

    always_comb begin
        w_mext = '0;
        case (w_funct3)
            3'd0: w_mext = w_prod[31:0];
            3'd1, 3'd2, 3'd3: w_mext = w_prod[63:32];
            3'd4: w_mext = w_div_zero ? 32'hFFFF_FFFF : (w_div_ovf ? 32'h8000_0000 : w_quot_s);
            3'd5: w_mext = w_div_zero ? 32'hFFFF_FFFF : w_rs1_val / w_rs2_val;
            3'd6: w_mext = w_div_zero ? w_rs1_val : (w_div_ovf ? 32'd0 : w_rem_s);
            default: w_mext = w_div_zero ? w_rs1_val : w_rs1_val % w_rs2_val;
        endcase
    end
`endif

    logic [31:0] w_addr, w_ld_word, w_ld_val;
    logic [7:0]  w_ld_byte;
    logic [15:0] w_ld_half;
    assign w_addr    = w_rs1_val + (w_is_store ? w_imm_s : w_imm_i);
    assign w_ld_word = 32'(data_RAM_i);
    assign w_ld_half = w_addr[1] ? w_ld_word[31:16] : w_ld_word[15:0];

    always_comb begin
        w_ld_byte = w_ld_word[7:0];
        case (w_addr[1:0])
            2'd1:    w_ld_byte = w_ld_word[15:8];
            2'd2:    w_ld_byte = w_ld_word[23:16];
            2'd3:    w_ld_byte = w_ld_word[31:24];
            default: w_ld_byte = w_ld_word[7:0];
        endcase
        case (w_funct3)
            3'd0:    w_ld_val = {{24{w_ld_byte[7]}}, w_ld_byte};
            3'd1:    w_ld_val = {{16{w_ld_half[15]}}, w_ld_half};
            3'd4:    w_ld_val = {24'd0, w_ld_byte};
            3'd5:    w_ld_val = {16'd0, w_ld_half};
            default: w_ld_val = w_ld_word;
        endcase
    end

    logic [3:0]  w_st_mask;
    logic [31:0] w_st_data;
    always_comb begin
        w_st_mask = 4'b0000;
        w_st_data = w_rs2_val;
        if (w_is_store) begin
            case (w_funct3)
                3'd0: begin
                    w_st_mask = 4'b0001 << w_addr[1:0];
                    w_st_data = {4{w_rs2_val[7:0]}};
                end
                3'd1: begin
                    w_st_mask = w_addr[1] ? 4'b1100 : 4'b0011;
                    w_st_data = {2{w_rs2_val[15:0]}};
                end
                default: w_st_mask = 4'b1111;
            endcase
        end
    end

    logic w_taken;
    always_comb begin
        case (w_funct3)
            3'd0:    w_taken = (w_rs1_val == w_rs2_val);
            3'd1:    w_taken = (w_rs1_val != w_rs2_val);
            3'd4:    w_taken = $signed(w_rs1_val) <  $signed(w_rs2_val);
            3'd5:    w_taken = $signed(w_rs1_val) >= $signed(w_rs2_val);
            3'd6:    w_taken = w_rs1_val <  w_rs2_val;
            3'd7:    w_taken = w_rs1_val >= w_rs2_val;
            default: w_taken = 1'b0;
        endcase
    end

    always_comb begin
        w_pc_next = w_pc_plus4;
        case (w_opcode)
            OPC_JAL:    w_pc_next = w_pc + w_imm_j;
            OPC_JALR:   w_pc_next = (w_rs1_val + w_imm_i) & ~32'd1;
            OPC_BRANCH: if (w_taken) w_pc_next = w_pc + w_imm_b;
            default:    w_pc_next = w_pc_plus4;
        endcase
    end

    logic        w_we;
    logic [31:0] w_wb;
    always_comb begin
        w_we = 1'b0;
        w_wb = '0;
        case (w_opcode)
            OPC_LUI:   begin w_we = 1'b1; w_wb = w_imm_u;         end
            OPC_AUIPC: begin w_we = 1'b1; w_wb = w_pc + w_imm_u;  end
            OPC_JAL,
            OPC_JALR:  begin w_we = 1'b1; w_wb = w_pc_plus4;      end
            OPC_LOAD:  begin w_we = 1'b1; w_wb = w_ld_val;        end
            OPC_OPIMM: begin w_we = 1'b1; w_wb = w_alu;           end
`ifdef RV32M_EN
            OPC_OP:    begin w_we = 1'b1; w_wb = w_is_mext ? w_mext : w_alu; end
`else
            OPC_OP:    begin w_we = !w_is_mext; w_wb = w_alu;     end
`endif
            default:   begin w_we = 1'b0; w_wb = '0;              end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            r_pc <= '0;
            for (int i = 0; i < 32; i++) r_regs[i] <= '0;
        end else begin
            r_pc <= PC_WIDTH'(w_pc_next);
            if (w_we && (w_rd != 5'd0)) r_regs[w_rd] <= w_wb;
        end
    end

    // The in-flight instruction is squashed while reset is high, so nothing reaches the RAM.
    assign pc_curr        = r_pc;
    assign mem_RAM_enable = !reset_n && (w_is_load || w_is_store);
    assign mem_wr_mask_o  = reset_n ? 4'b0000 : w_st_mask;
    assign addr_RAM_o     = reset_n ? '0 : ADDR_WIDTH'(w_addr);
    assign data_RAM_o     = reset_n ? '0 : DATA_WIDTH'(w_st_data);
endmodule

// File: tb/tb_rv32_core.sv
// Directed bench for rv32_core: hand-assembled programs, behavioural ROM/RAM, immediate assertions.
// Expected M-extension results follow RV32M_EN at compile time.
module tb_rv32_core;
`ifdef RV32M_EN
    localparam bit M_EN = 1'b1;
`else
    localparam bit M_EN = 1'b0;
`endif
    localparam logic [6:0] LUI = 7'h37, OPI = 7'h13, OP = 7'h33, LD = 7'h03, JALR = 7'h67;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [31:0] data_ROM, pc_curr, data_RAM_i, data_RAM_o, addr_RAM_o;
    logic [3:0]  mem_wr_mask_o;
    logic        mem_RAM_enable;
    logic [31:0] rom [64];
    logic [31:0] ram [256] = '{default: '0};
    int          n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    rv32_core dut (
        .clk(clk), .reset_n(reset_n), .data_ROM(data_ROM), .pc_curr(pc_curr),
        .data_RAM_i(data_RAM_i), .data_RAM_o(data_RAM_o), .addr_RAM_o(addr_RAM_o),
        .mem_wr_mask_o(mem_wr_mask_o), .mem_RAM_enable(mem_RAM_enable)
    );

    assign data_ROM   = rom[pc_curr[7:2]];
    assign data_RAM_i = ram[addr_RAM_o[9:2]];

    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (mem_wr_mask_o[b]) ram[addr_RAM_o[9:2]][8*b +: 8] <= data_RAM_o[8*b +: 8];
    end

    function automatic logic [31:0] i_t(logic [31:0] imm, rs1, f3, rd, logic [6:0] op);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
    endfunction
    function automatic logic [31:0] r_t(logic [31:0] f7, rs2, rs1, f3, rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], OP};
    endfunction
    function automatic logic [31:0] s_t(logic [31:0] imm, rs2, rs1, f3);
        return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] b_t(logic [31:0] imm, rs2, rs1, f3);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] j_t(logic [31:0] imm, rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6f};
    endfunction
    function automatic logic [31:0] u_t(logic [31:0] imm20, rd);
        return {imm20[19:0], rd[4:0], LUI};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to(input logic [31:0] target, input string tag);
        int n = 0;
        while (pc_curr !== target && n < 64) begin
            step();
            n++;
        end
        chk(tag, pc_curr, target);
    endtask

    task automatic chk_mem(input string tag, input logic [31:0] addr, input logic [3:0] mask,
                           input logic [31:0] data);
        chk({tag, ".en"}, {31'd0, mem_RAM_enable}, 32'd1);
        chk({tag, ".addr"}, addr_RAM_o, addr);
        chk({tag, ".mask"}, {28'd0, mem_wr_mask_o}, {28'd0, mask});
        if (mask != 4'b0000) chk({tag, ".data"}, data_RAM_o, data);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = 32'h0000_0013;
        // Program 1: ALU, x0, stores and loads
        rom[0]  = i_t(-5, 0, 0, 1, OPI);        // 00 ADDI x1,x0,-5
        rom[1]  = i_t(32'h401, 1, 5, 2, OPI);   // 04 SRAI x2,x1,1
        rom[2]  = r_t(0, 1, 0, 3, 3);           // 08 SLTU x3,x0,x1
        rom[3]  = s_t(0, 1, 0, 2);              // 0C SW x1,0(x0)
        rom[4]  = s_t(4, 2, 0, 2);              // 10 SW x2,4(x0)
        rom[5]  = s_t(8, 3, 0, 2);              // 14 SW x3,8(x0)
        rom[6]  = i_t(5, 0, 0, 0, OPI);         // 18 ADDI x0,x0,5
        rom[7]  = s_t(12, 0, 0, 2);             // 1C SW x0,12(x0)
        rom[8]  = i_t(32'h100, 0, 0, 1, OPI);   // 20 ADDI x1,x0,0x100
        rom[9]  = u_t(32'h12345, 2);            // 24 LUI x2,0x12345
        rom[10] = i_t(32'h678, 2, 0, 2, OPI);   // 28 ADDI x2,x2,0x678
        rom[11] = s_t(1, 2, 1, 0);              // 2C SB x2,1(x1)
        rom[12] = s_t(0, 2, 1, 2);              // 30 SW x2,0(x1)
        rom[13] = i_t(2, 1, 1, 3, LD);          // 34 LH x3,2(x1)
        rom[14] = s_t(4, 3, 1, 2);              // 38 SW x3,4(x1)
        rom[15] = i_t(32'h80, 0, 0, 4, OPI);    // 3C ADDI x4,x0,0x80
        rom[16] = s_t(11, 4, 1, 0);             // 40 SB x4,11(x1)
        rom[17] = i_t(11, 1, 0, 5, LD);         // 44 LB x5,11(x1)
        rom[18] = i_t(11, 1, 4, 13, LD);        // 48 LBU x13,11(x1)
        rom[19] = s_t(12, 5, 1, 2);             // 4C SW x5,12(x1)
        rom[20] = s_t(16, 13, 1, 2);            // 50 SW x13,16(x1)

        step();
        step();
        chk("rst.pc", pc_curr, 32'h0);
        chk("rst.en", {31'd0, mem_RAM_enable}, 32'd0);
        chk("rst.mask", {28'd0, mem_wr_mask_o}, 32'd0);
        reset_n = 1'b0;
        chk("pc0", pc_curr, 32'h0);
        step();
        chk("pc4", pc_curr, 32'h4);
        step();
        chk("pc8", pc_curr, 32'h8);

        run_to(32'h0C, "reach.0c"); chk_mem("sw_addi_neg5", 32'h0, 4'hF, 32'hFFFF_FFFB);
        run_to(32'h10, "reach.10"); chk_mem("sw_srai", 32'h4, 4'hF, 32'hFFFF_FFFD);
        run_to(32'h14, "reach.14"); chk_mem("sw_sltu", 32'h8, 4'hF, 32'h1);
        run_to(32'h1C, "reach.1c"); chk_mem("sw_x0", 32'hC, 4'hF, 32'h0);
        run_to(32'h2C, "reach.2c"); chk_mem("sb_lane1", 32'h101, 4'b0010, 32'h7878_7878);
        run_to(32'h30, "reach.30"); chk_mem("sw_word", 32'h100, 4'hF, 32'h1234_5678);
        run_to(32'h34, "reach.34"); chk_mem("lh_bus", 32'h102, 4'h0, 32'h0);
        run_to(32'h38, "reach.38"); chk_mem("lh_result", 32'h104, 4'hF, 32'h0000_1234);
        run_to(32'h40, "reach.40"); chk_mem("sb_lane3", 32'h10B, 4'b1000, 32'h8080_8080);
        run_to(32'h4C, "reach.4c"); chk_mem("lb_sext", 32'h10C, 4'hF, 32'hFFFF_FF80);
        run_to(32'h50, "reach.50"); chk_mem("lbu_zext", 32'h110, 4'hF, 32'h0000_0080);

        // Reset lands on an in-flight store: it must be squashed.
        reset_n = 1'b1;
        #1;
        chk("midrst.en", {31'd0, mem_RAM_enable}, 32'd0);
        chk("midrst.mask", {28'd0, mem_wr_mask_o}, 32'd0);
        chk("midrst.addr", addr_RAM_o, 32'h0);
        chk("midrst.data", data_RAM_o, 32'h0);

        // Program 2: control flow, NOP opcodes, M extension, register clearing
        for (int i = 0; i < 64; i++) rom[i] = 32'h0000_0013;
        rom[0]  = i_t(2, 0, 0, 1, OPI);         // 00 ADDI x1,x0,2
        rom[1]  = i_t(0, 0, 0, 2, OPI);         // 04 ADDI x2,x0,0
        rom[2]  = i_t(1, 2, 0, 2, OPI);         // 08 ADDI x2,x2,1
        rom[4]  = b_t(-8, 2, 1, 1);             // 10 BNE x1,x2,-8
        rom[5]  = 32'h0000_0073;                // 14 ECALL
        rom[6]  = r_t(1, 1, 1, 0, 2);           // 18 MUL x2,x1,x1
        rom[8]  = j_t(12, 1);                   // 20 JAL x1,+12
        rom[9]  = s_t(60, 0, 0, 2);             // 24 (skipped)
        rom[10] = s_t(60, 0, 0, 2);             // 28 (skipped)
        rom[11] = s_t(0, 1, 0, 2);              // 2C SW x1,0(x0)
        rom[12] = s_t(4, 2, 0, 2);              // 30 SW x2,4(x0)
        rom[13] = i_t(32'h41, 0, 0, 3, OPI);    // 34 ADDI x3,x0,0x41
        rom[14] = i_t(0, 3, 0, 4, JALR);        // 38 JALR x4,0(x3)
        rom[15] = s_t(60, 0, 0, 2);             // 3C (skipped)
        rom[16] = s_t(8, 4, 0, 2);              // 40 SW x4,8(x0)
        rom[17] = i_t(7, 0, 0, 5, OPI);         // 44 ADDI x5,x0,7
        rom[18] = i_t(-3, 0, 0, 6, OPI);        // 48 ADDI x6,x0,-3
        rom[19] = i_t(5, 0, 0, 11, OPI);        // 4C ADDI x11,x0,5
        rom[20] = r_t(1, 6, 5, 0, 7);           // 50 MUL x7,x5,x6
        rom[21] = r_t(1, 0, 5, 4, 8);           // 54 DIV x8,x5,x0
        rom[22] = u_t(32'h80000, 9);            // 58 LUI x9,0x80000
        rom[23] = i_t(-1, 0, 0, 10, OPI);       // 5C ADDI x10,x0,-1
        rom[24] = r_t(1, 10, 9, 6, 11);         // 60 REM x11,x9,x10
        rom[25] = r_t(1, 10, 9, 4, 12);         // 64 DIV x12,x9,x10
        rom[26] = s_t(12, 7, 0, 2);             // 68 SW x7,12(x0)
        rom[27] = s_t(16, 8, 0, 2);             // 6C SW x8,16(x0)
        rom[28] = s_t(20, 11, 0, 2);            // 70 SW x11,20(x0)
        rom[29] = s_t(24, 12, 0, 2);            // 74 SW x12,24(x0)
        rom[30] = s_t(28, 13, 0, 2);            // 78 SW x13,28(x0)
        rom[31] = b_t(0, 0, 0, 0);              // 7C BEQ x0,x0,0

        step();
        chk("midrst.pc", pc_curr, 32'h0);
        chk("midrst.nowrite", ram[32'h110 >> 2], 32'h0);
        reset_n = 1'b0;

        run_to(32'h10, "reach.bne1");
        step();
        chk("bne_taken", pc_curr, 32'h08);
        run_to(32'h10, "reach.bne2");
        step();
        chk("bne_fall", pc_curr, 32'h14);
        chk("ecall.en", {31'd0, mem_RAM_enable}, 32'd0);
        step();
        chk("ecall.pc", pc_curr, 32'h18);
        run_to(32'h20, "reach.jal");
        step();
        chk("jal.pc", pc_curr, 32'h2C);
        chk_mem("jal.link", 32'h0, 4'hF, 32'h24);
        run_to(32'h30, "reach.30b");
        chk_mem("mul_small", 32'h4, 4'hF, M_EN ? 32'd4 : 32'd2);
        run_to(32'h38, "reach.jalr");
        step();
        chk("jalr.pc", pc_curr, 32'h40);
        chk_mem("jalr.link", 32'h8, 4'hF, 32'h3C);
        run_to(32'h68, "reach.68"); chk_mem("mul_neg", 32'hC, 4'hF, M_EN ? 32'hFFFF_FFEB : 32'h0);
        run_to(32'h6C, "reach.6c"); chk_mem("div_zero", 32'h10, 4'hF, M_EN ? 32'hFFFF_FFFF : 32'h0);
        run_to(32'h70, "reach.70"); chk_mem("rem_ovf", 32'h14, 4'hF, M_EN ? 32'h0 : 32'd5);
        run_to(32'h74, "reach.74"); chk_mem("div_ovf", 32'h18, 4'hF, M_EN ? 32'h8000_0000 : 32'h0);
        run_to(32'h78, "reach.78"); chk_mem("reg_cleared", 32'h1C, 4'hF, 32'h0);
        run_to(32'h7C, "reach.loop");
        step();
        step();
        chk("selfloop", pc_curr, 32'h7C);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
